gate_seq_ctrl: RTL and testbench
================================

Name: gate_seq_ctrl

Overview:
Gate-time sequencer for the frequency-counter datapath. It drives the clear, enable and latch strobes of an external event counter so that counting happens over a programmable number of reference-clock cycles. It then holds the result valid until a reader acknowledges it. It supports single-shot and continuous measurement, abort, and a completed-gate tally.

Parameters:
W, 32, width of gate-length register and timer
DEFAULT_GATE, 10000000, gate length in CLK cycles after reset
MIN_GATE, 2, smallest accepted gate length; smaller loads are clamped up to this value

Ports:
CLK  input  1  reference clock; all logic on posedge
RST  input  1  synchronous active-high reset
START  input  1  request one measurement; sampled only in IDLE
CONT  input  1  continuous mode; sampled on ACK in HOLD
ABORT  input  1  cancel current measurement
DIV_LD  input  1  load gate length from DIV_IN
DIV_IN  input  W  requested gate length in CLK cycles
ACK  input  1  reader has taken the latched result
CNT_CLR  output  1  one-cycle clear strobe to the event counter
CNT_EN  output  1  count enable; high for exactly gate_len cycles
CNT_LATCH  output  1  one-cycle strobe to capture the counter value
READY  output  1  latched result valid
BUSY  output  1  high in every state except IDLE
CFG_ERR  output  1  one-cycle pulse when DIV_LD is rejected
GATE_NUM  output  16  count of completed gates; wraps modulo 2^16

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high. All outputs are registered.
- Reset state:
  - state = IDLE, gate_len = DEFAULT_GATE, timer = 0, GATE_NUM = 0.
  - CNT_CLR, CNT_EN, CNT_LATCH, READY, BUSY and CFG_ERR are all 0.
  - RST overrides every other input in any state, including mid-gate.
- Configuration:
  - DIV_LD in IDLE sets gate_len = (DIV_IN < MIN_GATE) ? MIN_GATE : DIV_IN.
  - DIV_LD in any other state is ignored, gate_len is unchanged, and CFG_ERR pulses high on the next cycle.
  - DIV_LD and START in the same IDLE cycle: the load takes effect, and the started gate uses the new length.
- IDLE: START = 1 -> CLEAR. ACK, CONT and ABORT are ignored.
- CLEAR (1 cycle):
  - CNT_CLR = 1, timer loads gate_len - 1, next state GATE.
  - ABORT = 1 -> IDLE instead.
- GATE:
  - CNT_EN = 1 every cycle; timer decrements each cycle.
  - When timer = 0 -> LATCH.
  - ABORT = 1 -> IDLE; CNT_EN drops on the next cycle, no latch, GATE_NUM unchanged.
- LATCH (1 cycle): CNT_LATCH = 1, GATE_NUM increments, next state HOLD.
- HOLD:
  - READY = 1 until ACK is sampled.
  - ACK with CONT = 1 -> CLEAR (no IDLE cycle).
  - ACK with CONT = 0 -> IDLE.
  - ABORT -> IDLE. ACK and ABORT together -> IDLE regardless of CONT.
- START while BUSY is ignored, and no request is queued.
- Timing, with START sampled at edge k and gate length N:
  - CNT_CLR high in cycle k+1.
  - CNT_EN high in cycles k+2 .. k+1+N (exactly N cycles).
  - CNT_LATCH high in cycle k+2+N.
  - READY high from cycle k+3+N.
  - BUSY high from cycle k+1 until the cycle after ACK.
  - CNT_CLR, CNT_EN and CNT_LATCH are mutually exclusive.
- Arithmetic: timer is W bits and unsigned. Because gate_len >= MIN_GATE >= 2, gate_len - 1 never underflows. GATE_NUM wraps 0xFFFF -> 0x0000.

Test Plan:
- Single shot: RST, DIV_LD with DIV_IN = 5, START pulse -> CNT_CLR for 1 cycle, CNT_EN for exactly 5 cycles, CNT_LATCH for 1 cycle; READY stays 1 until ACK, then BUSY = 0 and GATE_NUM = 1.
- Clamp and reset default: DIV_IN = 0 -> CNT_EN width 2. RST alone then START -> CNT_EN width 10000000, or DEFAULT_GATE overridden to 20 in the bench -> width 20.
- Continuous: DIV_IN = 3, START, hold CONT = 1, ACK each READY -> CNT_CLR follows ACK by one cycle with no IDLE gap; GATE_NUM = 4 after four gates.
- Abort mid-gate: DIV_IN = 10, ABORT on the 4th CNT_EN cycle -> CNT_EN = 0 next cycle, no CNT_LATCH, READY = 0, GATE_NUM unchanged, BUSY = 0.
- Protection: DIV_LD = 7 during GATE -> CFG_ERR pulses once and the current and next gates keep the old length. START during HOLD is ignored. ACK and ABORT together in HOLD with CONT = 1 -> IDLE.
- Reset mid-operation and wrap: RST during GATE -> all outputs 0 next cycle and gate_len = DEFAULT_GATE. Force GATE_NUM to 0xFFFF, complete one gate -> GATE_NUM = 0x0000.

Source files
------------

// File: rtl/gate_seq_ctrl_if.sv
// Control/status bundle between the frequency-counter host logic and the gate sequencer.
// The master drives requests and configuration; the slave (sequencer) drives strobes and status.
interface gate_seq_ctrl_if #(
    parameter int W = 32
);
    logic         START;
    logic         CONT;
    logic         ABORT;
    logic         DIV_LD;
    logic [W-1:0] DIV_IN;
    logic         ACK;
    logic         CNT_CLR;
    logic         CNT_EN;
    logic         CNT_LATCH;
    logic         READY;
    logic         BUSY;
    logic         CFG_ERR;
    logic [15:0]  GATE_NUM;

    modport master (
        output START, CONT, ABORT, DIV_LD, DIV_IN, ACK,
        input  CNT_CLR, CNT_EN, CNT_LATCH, READY, BUSY, CFG_ERR, GATE_NUM
    );

    modport slave (
        input  START, CONT, ABORT, DIV_LD, DIV_IN, ACK,
        output CNT_CLR, CNT_EN, CNT_LATCH, READY, BUSY, CFG_ERR, GATE_NUM
    );
endinterface

// File: rtl/gate_seq_ctrl.sv
// Gate-time sequencer: clear -> N enable cycles -> latch -> hold result until ACK; all outputs registered,
// CNT_CLR one cycle after START. No request queue: START while busy is dropped, result held until ACK.
module gate_seq_ctrl #(
    parameter int           W            = 32,
    parameter logic [W-1:0] DEFAULT_GATE = W'(10000000),
    parameter logic [W-1:0] MIN_GATE     = W'(2)
) (
    input  logic           CLK,
    input  logic           RST,
    gate_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_LATCH,
        S_HOLD
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_gate_len;
    logic [W-1:0] r_timer;
    logic [W-1:0] w_gate_len_ld;
    logic [15:0]  r_gate_num;
    logic         r_cnt_clr;
    logic         r_cnt_en;
    logic         r_cnt_latch;
    logic         r_ready;
    logic         r_busy;
    logic         r_cfg_err;

    always_comb begin
        w_state_nxt   = r_state;
        w_gate_len_ld = (bus.DIV_IN < MIN_GATE) ? MIN_GATE : bus.DIV_IN;
        case (r_state)
            S_IDLE: begin
                if (bus.START) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_state_nxt = bus.ABORT ? S_IDLE : S_GATE;
            end
            S_GATE: begin
                if (bus.ABORT)             w_state_nxt = S_IDLE;
                else if (r_timer == '0)    w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                // ABORT wins over ACK, so a continuous run can always be stopped from HOLD
                if (bus.ABORT)             w_state_nxt = S_IDLE;
                else if (bus.ACK)          w_state_nxt = bus.CONT ? S_CLEAR : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_gate_len  <= DEFAULT_GATE;
            r_timer     <= '0;
            r_gate_num  <= '0;
            r_cnt_clr   <= 1'b0;
            r_cnt_en    <= 1'b0;
            r_cnt_latch <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_err <= bus.DIV_LD && (r_state != S_IDLE);

            if (bus.DIV_LD && (r_state == S_IDLE)) r_gate_len <= w_gate_len_ld;

            if (r_state == S_CLEAR)                      r_timer <= r_gate_len - W'(1);
            else if (r_state == S_GATE && r_timer != '0) r_timer <= r_timer - W'(1);

            if (r_state == S_LATCH) r_gate_num <= r_gate_num + 16'd1;

            // Strobes are decoded from the next state so they line up with the state they belong to
            r_cnt_clr   <= (w_state_nxt == S_CLEAR);
            r_cnt_en    <= (w_state_nxt == S_GATE);
            r_cnt_latch <= (w_state_nxt == S_LATCH);
            r_ready     <= (w_state_nxt == S_HOLD);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.CNT_CLR   = r_cnt_clr;
    assign bus.CNT_EN    = r_cnt_en;
    assign bus.CNT_LATCH = r_cnt_latch;
    assign bus.READY     = r_ready;
    assign bus.BUSY      = r_busy;
    assign bus.CFG_ERR   = r_cfg_err;
    assign bus.GATE_NUM  = r_gate_num;
endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Bench for gate_seq_ctrl: directed scenarios plus random traffic, every cycle compared
// against a measurement-timeline model (strobes derived from cycles elapsed since START).
module tb_gate_seq_ctrl;
    localparam int W   = 32;
    localparam int DEF = 20;
    localparam int MIN = 2;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    gate_seq_ctrl_if #(.W(W)) bus ();

    gate_seq_ctrl #(
        .W            (W),
        .DEFAULT_GATE (W'(DEF)),
        .MIN_GATE     (W'(MIN))
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int en_cnt = 0;

    // model: m_t = cycles since the START edge within the current measurement
    bit m_act = 0;
    int m_t   = 0;
    int m_len = DEF;
    int m_num = 0;
    bit m_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [21:0] exp_outs();
        logic clr, en, lat, rdy;
        clr = m_act && (m_t == 1);
        en  = m_act && (m_t >= 2) && (m_t <= m_len + 1);
        lat = m_act && (m_t == m_len + 2);
        rdy = m_act && (m_t >= m_len + 3);
        return {clr, en, lat, rdy, m_act, m_err, m_num[15:0]};
    endfunction

    function automatic logic [21:0] dut_outs();
        return {bus.CNT_CLR, bus.CNT_EN, bus.CNT_LATCH, bus.READY, bus.BUSY, bus.CFG_ERR, bus.GATE_NUM};
    endfunction

    task automatic model_edge();
        if (RST) begin
            m_act = 0; m_len = DEF; m_num = 0; m_err = 0; m_t = 0;
            return;
        end
        m_err = bus.DIV_LD && m_act;
        if (!m_act) begin
            if (bus.DIV_LD) m_len = (bus.DIV_IN < MIN) ? MIN : int'(bus.DIV_IN);
            if (bus.START) begin m_act = 1; m_t = 1; end
        end else if (m_t == m_len + 2) begin
            m_num = (m_num + 1) & 16'hFFFF;
            m_t++;
        end else if (m_t >= m_len + 3) begin
            if (bus.ABORT)    m_act = 0;
            else if (bus.ACK) begin
                if (bus.CONT) m_t = 1;
                else          m_act = 0;
            end
        end else begin
            if (bus.ABORT) m_act = 0;
            else           m_t++;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        if (bus.CNT_EN) en_cnt++;
        chk("outs", 32'(dut_outs()), 32'(exp_outs()));
    endtask

    task automatic pulses_off();
        RST = 0; bus.START = 0; bus.ABORT = 0; bus.DIV_LD = 0; bus.ACK = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_ready(input string tag, input int bound);
        int k;
        k = 0;
        while (!(m_act && m_t >= m_len + 3) && k < bound) begin step(); k++; end
        if (k >= bound) chk({tag, "_timeout"}, 32'(k), 32'(bound + 1));
    endtask

    task automatic start_gate(input bit ld, input int len);
        en_cnt = 0;
        bus.DIV_LD = ld; bus.DIV_IN = W'(len); bus.START = 1;
        step();
        pulses_off();
    endtask

    task automatic ack_once();
        bus.ACK = 1; step(); pulses_off();
    endtask

    initial begin
        RST = 1; bus.START = 0; bus.CONT = 0; bus.ABORT = 0; bus.DIV_LD = 0; bus.DIV_IN = '0; bus.ACK = 0;
        step();
        pulses_off();
        steps(2);

        // single shot, length 5 loaded beforehand
        bus.DIV_LD = 1; bus.DIV_IN = 5; step(); pulses_off();
        start_gate(0, 0);
        run_until_ready("single", 20);
        chk("single_en_width", 32'(en_cnt), 32'd5);
        steps(3);
        ack_once();
        chk("single_num", 32'(bus.GATE_NUM), 32'd1);
        steps(2);

        // clamp: load 0 together with START
        start_gate(1, 0);
        run_until_ready("clamp", 20);
        chk("clamp_en_width", 32'(en_cnt), 32'd2);
        ack_once();

        // reset restores the default length
        RST = 1; step(); pulses_off();
        start_gate(0, 0);
        run_until_ready("default", 40);
        chk("default_en_width", 32'(en_cnt), 32'(DEF));
        ack_once();

        // continuous mode, four gates with no IDLE gap
        bus.DIV_LD = 1; bus.DIV_IN = 3; step(); pulses_off();
        bus.CONT = 1;
        start_gate(0, 0);
        for (int g = 0; g < 4; g++) begin
            run_until_ready("cont", 20);
            chk("cont_en_width", 32'(en_cnt), 32'd3);
            en_cnt = 0;
            if (g < 3) begin
                ack_once();
                chk("cont_clr_after_ack", 32'(bus.CNT_CLR), 32'd1);
            end
        end
        bus.CONT = 0;
        ack_once();
        chk("cont_num", 32'(bus.GATE_NUM), 32'd5);

        // abort on the 4th enable cycle
        start_gate(1, 10);
        while (m_act && m_t < 5) step();
        bus.ABORT = 1; step(); pulses_off();
        chk("abort_en_width", 32'(en_cnt), 32'd4);
        chk("abort_busy", 32'(bus.BUSY), 32'd0);
        steps(3);
        chk("abort_num", 32'(bus.GATE_NUM), 32'd5);

        // load during GATE is rejected, START in HOLD ignored, ACK+ABORT beats CONT
        start_gate(1, 4);
        steps(2);
        bus.DIV_LD = 1; bus.DIV_IN = 7; step(); pulses_off();
        chk("cfg_err_pulse", 32'(bus.CFG_ERR), 32'd1);
        run_until_ready("prot", 20);
        chk("prot_en_width", 32'(en_cnt), 32'd4);
        bus.START = 1; step(); pulses_off();
        chk("hold_start_ignored", 32'(bus.READY), 32'd1);
        bus.CONT = 1; en_cnt = 0;
        ack_once();
        run_until_ready("prot2", 20);
        chk("prot_next_en_width", 32'(en_cnt), 32'd4);
        bus.ACK = 1; bus.ABORT = 1; step(); pulses_off();
        bus.CONT = 0;
        chk("ack_abort_idle", 32'(bus.BUSY), 32'd0);
        steps(2);

        // reset mid-gate
        start_gate(0, 0);
        steps(3);
        RST = 1; step(); pulses_off();
        chk("rst_outs", 32'(dut_outs()), 32'd0);
        start_gate(0, 0);
        run_until_ready("rst_default", 40);
        chk("rst_default_en_width", 32'(en_cnt), 32'(DEF));
        ack_once();

        // gate counter wrap
        @(negedge CLK);
        force dut.r_gate_num = 16'hFFFF;
        m_num = 16'hFFFF;
        step();
        @(negedge CLK);
        release dut.r_gate_num;
        step();
        start_gate(1, 2);
        run_until_ready("wrap", 20);
        chk("wrap_num", 32'(bus.GATE_NUM), 32'd0);
        ack_once();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            RST         = ($urandom_range(0, 199) == 0);
            bus.START   = ($urandom_range(0, 4) == 0);
            bus.ABORT   = ($urandom_range(0, 39) == 0);
            bus.DIV_LD  = ($urandom_range(0, 14) == 0);
            bus.DIV_IN  = W'($urandom_range(0, 12));
            bus.ACK     = ($urandom_range(0, 2) == 0);
            bus.CONT    = $urandom_range(0, 1) != 0;
            step();
        end
        pulses_off();
        bus.CONT = 0;
        steps(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
